// File: rtl/pipe_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_pkg : shared hazard-controller state codes, R0 and control type |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] HZ_RUN = 2'd0;
  localparam logic [1:0] HZ_BR  = 2'd1;
  localparam logic [1:0] HZ_MEM = 2'd2;

  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic d_flush;
    logic flush;
    logic pc_sel_br;
    logic exmem_en;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_IDLE = '{
    pc_en:      1'b1,
    ifid_en:    1'b1,
    ifid_flush: 1'b0,
    idex_en:    1'b1,
    d_flush:    1'b0,
    flush:      1'b0,
    pc_sel_br:  1'b0,
    exmem_en:   1'b1
  };

  function automatic logic src_hit(input logic       uses,
                                   input logic [3:0] src,
                                   input logic [3:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_sat_cnt16.sv
// +----------------------------------------------------------------------+
// | sat_cnt16 : 16-bit saturating counter, sync active-low clear         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | hazard_ctrl : load-use / branch / memory-freeze pipeline control.    |
// | Optional perf counters built only with HAZARD_PERF_EN.  Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_SrcReg1,
  input  logic [3:0]  id_SrcReg2,
  input  logic        id_uses1,
  input  logic        id_uses2,
  input  logic        ex_Data_Mem_en,
  input  logic        ex_Data_Mem_wr,
  input  logic [3:0]  ex_DstReg,
  input  logic        ex_flush,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        d_flush,
  output logic        flush,
  output logic        pc_sel_br,
  output logic        exmem_en,
  output logic        mem_err,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [7:0] tmo_q;
  logic [7:0] tmo_d;
  logic       mem_err_q;
  logic       mem_err_d;

  logic       lu;
  logic       br;
  logic       in_shadow;
  hz_ctrl_t   ctrl;

  assign br = ex_branch_taken & ~ex_flush;

  assign lu = ex_Data_Mem_en & ~ex_Data_Mem_wr & ~ex_flush &
              (ex_DstReg != REG_ZERO) &
              (src_hit(id_uses1, id_SrcReg1, ex_DstReg) |
               src_hit(id_uses2, id_SrcReg2, ex_DstReg));

  // ID holds the killed-path NOP during the shadow, so neither a second
  // branch nor a load-use match can be genuine there.
  assign in_shadow = (state_q == HZ_BR);

  always_comb begin
    ctrl      = HZ_CTRL_IDLE;
    state_d   = HZ_RUN;
    tmo_d     = '0;
    mem_err_d = mem_err_q;

    if (mem_busy) begin
      ctrl.pc_en    = 1'b0;
      ctrl.ifid_en  = 1'b0;
      ctrl.idex_en  = 1'b0;
      ctrl.exmem_en = 1'b0;
      state_d       = HZ_MEM;
      if (state_q == HZ_MEM) begin
        tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
      end else begin
        tmo_d = 8'd1;
      end
      if (tmo_d >= TIMEOUT_LIM) begin
        mem_err_d = 1'b1;
      end
    end else if (br && !in_shadow) begin
      ctrl.flush      = 1'b1;
      ctrl.ifid_flush = 1'b1;
      ctrl.pc_sel_br  = 1'b1;
      state_d         = HZ_BR;
    end else if (lu && !in_shadow) begin
      ctrl.pc_en   = 1'b0;
      ctrl.ifid_en = 1'b0;
      ctrl.d_flush = 1'b1;
      ctrl.idex_en = 1'b1;
    end

    if (!rst) begin
      ctrl = HZ_CTRL_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= HZ_RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_en    = ctrl.idex_en;
  assign d_flush    = ctrl.d_flush;
  assign flush      = ctrl.flush;
  assign pc_sel_br  = ctrl.pc_sel_br;
  assign exmem_en   = ctrl.exmem_en;
  assign mem_err    = mem_err_q;

`ifdef HAZARD_PERF_EN
  sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (~ctrl.pc_en),
    .cnt_o (stall_cycles)
  );

  sat_cnt16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (ctrl.flush | ctrl.d_flush),
    .cnt_o (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

`default_nettype wire
